// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between the MEM-stage load/store port
//   (C) and the DMA / program-loader port (D). One requester is granted per
//   cycle (combinational grant). An owner may keep the memory for bounded
//   bursts while the other port waits, and contention alternates round-robin.
//   Read data comes back registered with a one-cycle rvalid pulse, and
//   out-of-range accesses return an error pulse instead of touching memory.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata  port C request
//   c_gnt, c_stall             port C grant (comb), stall to hazard unit
//   c_rvalid/c_err/c_rdata     port C registered response
//   d_*                        same as port C for port D (no stall)
//   m_we/m_addr/m_wdata        memory drive
//   m_rdata                    memory combinational read data for m_addr
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
  parameter int AW        = 64,
  parameter int DW        = 64,
  parameter int DEPTH     = 1024,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  // port C (MEM stage)
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic          c_err,
  output logic [DW-1:0] c_rdata,
  // port D (DMA / loader)
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic          d_err,
  output logic [DW-1:0] d_rdata,
  // memory side
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int            CW      = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  // Owner and selection share one encoding so own can be loaded from sel.
  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_C    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic LAST_C = 1'b0;
  localparam logic LAST_D = 1'b1;

  logic [1:0]    own;
  logic [1:0]    sel;
  logic [CW-1:0] cnt;
  logic          last;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          in_range;

  //----------------------------------------------------------------------------
  // State register (arbitration state plus registered responses)
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own      <= OWN_IDLE;
      cnt      <= '0;
      last     <= LAST_D;   // C wins the first contended cycle
      c_rvalid <= 1'b0;
      c_err    <= 1'b0;
      c_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      own <= sel;

      // Burst counter: counts repeat grants to the same owner, saturating.
      if (sel != OWN_IDLE && sel == own)
        cnt <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      else
        cnt <= '0;

      if (sel != OWN_IDLE)
        last <= (sel == OWN_C) ? LAST_C : LAST_D;

      c_rvalid <= c_gnt & ~c_we;
      c_err    <= c_gnt & ~in_range;
      // rdata updates on any read response or error; otherwise it holds.
      if (c_gnt && (!c_we || !in_range))
        c_rdata <= in_range ? m_rdata : '0;

      d_rvalid <= d_gnt & ~d_we;
      d_err    <= d_gnt & ~in_range;
      if (d_gnt && (!d_we || !in_range))
        d_rdata <= in_range ? m_rdata : '0;
    end
  end

  //----------------------------------------------------------------------------
  // Next-state: requester selection
  //----------------------------------------------------------------------------
  always_comb begin
    sel = OWN_IDLE;
    // No grant while reset is asserted, so nothing can reach memory.
    if (rst) begin
      case (own)
        OWN_C: begin
          if (c_req && (cnt < CNT_MAX || !d_req)) sel = OWN_C;
          else if (d_req)                         sel = OWN_D;
        end
        OWN_D: begin
          if (d_req && (cnt < CNT_MAX || !c_req)) sel = OWN_D;
          else if (c_req)                         sel = OWN_C;
        end
        default: begin
          if (c_req && d_req) sel = (last == LAST_D) ? OWN_C : OWN_D;
          else if (c_req)     sel = OWN_C;
          else if (d_req)     sel = OWN_D;
        end
      endcase
    end
  end

  //----------------------------------------------------------------------------
  // Outputs: grants and memory drive
  //----------------------------------------------------------------------------
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (sel)
      OWN_C: begin
        sel_we    = c_we;
        sel_addr  = c_addr;
        sel_wdata = c_wdata;
      end
      OWN_D: begin
        sel_we    = d_we;
        sel_addr  = d_addr;
        sel_wdata = d_wdata;
      end
      default: ;
    endcase

    in_range = (sel_addr < AW'(DEPTH));

    c_gnt   = (sel == OWN_C);
    d_gnt   = (sel == OWN_D);
    c_stall = c_req & ~c_gnt;

    m_addr  = sel_addr;
    m_wdata = sel_wdata;
    m_we    = sel_we & in_range & rst;
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed self-checking bench for dmem_arbiter. A small behavioural memory
//   (combinational read, write on the rising edge, address aliased to 10 bits
//   so a stray out-of-range write would corrupt a visible word) is attached.
//   Word a starts as a*0x1111 + 0x5A.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [63:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_stall, c_rvalid, c_err;
  logic        d_gnt, d_rvalid, d_err;
  logic [63:0] c_rdata, d_rdata;
  logic        m_we;
  logic [63:0] m_addr, m_wdata, m_rdata;

  logic [63:0] mem [0:1023];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_stall  (c_stall),
    .c_rvalid (c_rvalid),
    .c_err    (c_err),
    .c_rdata  (c_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_err    (d_err),
    .d_rdata  (d_rdata),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  assign m_rdata = (m_addr < 64'd1024) ? mem[m_addr[9:0]] : 64'd0;

  // Memory model: initial contents and rising-edge writes in one process.
  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 64'(k) * 64'h1111 + 64'h5A;
    forever begin
      @(posedge clk);
      if (m_we) mem[m_addr[9:0]] <= m_wdata;
    end
  end

  function automatic logic [63:0] init_word(input int a);
    return 64'(a) * 64'h1111 + 64'h5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] exp_c;
    exp_c = 9'b1_0000_1111;  // C,C,C,C,D,D,D,D,C (bit i = cycle i)

    // ---------------- reset held with both ports requesting ----------------
    rst = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 64'd3; c_wdata = 64'h1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd4; d_wdata = 64'h2;
    tick(); tick();
    chk("rst_c_gnt",    {63'd0, c_gnt},    64'd0);
    chk("rst_d_gnt",    {63'd0, d_gnt},    64'd0);
    chk("rst_m_we",     {63'd0, m_we},     64'd0);
    chk("rst_c_rvalid", {63'd0, c_rvalid}, 64'd0);
    chk("rst_d_rvalid", {63'd0, d_rvalid}, 64'd0);
    chk("rst_c_err",    {63'd0, c_err},    64'd0);
    chk("rst_d_err",    {63'd0, d_err},    64'd0);
    chk("rst_c_rdata",  c_rdata,           64'd0);
    chk("rst_d_rdata",  d_rdata,           64'd0);

    // ---------------- release: continuous contention, MAX_BURST=4 ----------
    rst = 1'b1;
    c_we = 1'b0; c_addr = 64'd20;
    d_we = 1'b0; d_addr = 64'd21;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("burst_c_gnt[%0d]", i),   {63'd0, c_gnt},   {63'd0, exp_c[i]});
      chk($sformatf("burst_d_gnt[%0d]", i),   {63'd0, d_gnt},   {63'd0, ~exp_c[i]});
      chk($sformatf("burst_c_stall[%0d]", i), {63'd0, c_stall}, {63'd0, ~exp_c[i]});
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    tick();

    // ---------------- C write then read of address 5 -----------------------
    c_req = 1'b1; c_we = 1'b1; c_addr = 64'd5; c_wdata = 64'hDEAD_BEEF_0123_4567;
    #1;
    chk("cw_c_gnt",   {63'd0, c_gnt}, 64'd1);
    chk("cw_d_gnt",   {63'd0, d_gnt}, 64'd0);
    chk("cw_m_we",    {63'd0, m_we},  64'd1);
    chk("cw_m_addr",  m_addr,         64'd5);
    chk("cw_m_wdata", m_wdata,        64'hDEAD_BEEF_0123_4567);
    tick();
    c_we = 1'b0;
    chk("cw_no_rvalid", {63'd0, c_rvalid}, 64'd0);
    #1;
    chk("cr_c_gnt", {63'd0, c_gnt}, 64'd1);
    chk("cr_m_we",  {63'd0, m_we},  64'd0);
    tick();
    c_req = 1'b0;
    chk("cr_rvalid", {63'd0, c_rvalid}, 64'd1);
    chk("cr_rdata",  c_rdata,           64'hDEAD_BEEF_0123_4567);
    chk("cr_err",    {63'd0, c_err},    64'd0);
    chk("cr_d_gnt",  {63'd0, d_gnt},    64'd0);
    tick();
    chk("cr_pulse",  {63'd0, c_rvalid}, 64'd0);
    chk("cr_hold",   c_rdata,           64'hDEAD_BEEF_0123_4567);

    // ---------------- uncontended D burst of 10 back-to-back reads ---------
    d_req = 1'b1; d_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d_addr = 64'(10 + i);
      #1;
      chk($sformatf("dburst_d_gnt[%0d]", i), {63'd0, d_gnt}, 64'd1);
      chk($sformatf("dburst_c_gnt[%0d]", i), {63'd0, c_gnt}, 64'd0);
      tick();
      chk($sformatf("dburst_rvalid[%0d]", i), {63'd0, d_rvalid}, 64'd1);
      chk($sformatf("dburst_rdata[%0d]", i),  d_rdata,           init_word(10 + i));
    end
    d_req = 1'b0;
    tick();

    // ---------------- out-of-range write then read -------------------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd1024; d_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("oorw_d_gnt", {63'd0, d_gnt}, 64'd1);
    chk("oorw_m_we",  {63'd0, m_we},  64'd0);
    tick();
    chk("oorw_err",    {63'd0, d_err},    64'd1);
    chk("oorw_rvalid", {63'd0, d_rvalid}, 64'd0);
    d_we = 1'b0; d_addr = 64'd2000;
    #1;
    chk("oorr_d_gnt", {63'd0, d_gnt}, 64'd1);
    tick();
    chk("oorr_rvalid", {63'd0, d_rvalid}, 64'd1);
    chk("oorr_err",    {63'd0, d_err},    64'd1);
    chk("oorr_rdata",  d_rdata,           64'd0);
    // Read back word 0 (alias of 1024): must be untouched.
    d_addr = 64'd0;
    tick();
    d_req = 1'b0;
    chk("oor_mem0_rvalid", {63'd0, d_rvalid}, 64'd1);
    chk("oor_mem0_err",    {63'd0, d_err},    64'd0);
    chk("oor_mem0_rdata",  d_rdata,           init_word(0));
    tick();

    // ---------------- reset in the cycle after a read grant ----------------
    c_req = 1'b1; c_we = 1'b0; c_addr = 64'd7;
    #1;
    chk("mrst_c_gnt", {63'd0, c_gnt}, 64'd1);
    tick();
    chk("mrst_rvalid_before", {63'd0, c_rvalid}, 64'd1);
    rst = 1'b0;
    #1;
    chk("mrst_rvalid_drop", {63'd0, c_rvalid}, 64'd0);
    chk("mrst_rdata_clr",   c_rdata,           64'd0);
    c_addr = 64'd8; d_req = 1'b1; d_we = 1'b0; d_addr = 64'd9;
    tick();
    chk("mrst_no_resp", {63'd0, c_rvalid}, 64'd0);
    chk("mrst_gnt_off", {63'd0, c_gnt},    64'd0);
    rst = 1'b1;
    #1;
    chk("mrst_restart_c", {63'd0, c_gnt}, 64'd1);
    chk("mrst_restart_d", {63'd0, d_gnt}, 64'd0);
    tick();
    c_req = 1'b0; d_req = 1'b0;
    chk("mrst_after_rvalid", {63'd0, c_rvalid}, 64'd1);
    chk("mrst_after_rdata",  c_rdata,           init_word(8));
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
